// File: rtl/width_8to16_arb.sv
// Two-requester byte-pair arbiter and 8-to-16 packer with a round-robin grant per pair,
// a registered word output and a timeout that drops a stranded first byte.
module width_8to16_arb #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s0_valid,
  input  logic [7:0]  s0_data,
  output logic        s0_ready,
  input  logic        s1_valid,
  input  logic [7:0]  s1_data,
  output logic        s1_ready,
  output logic        m_valid,
  output logic [15:0] m_data,
  output logic        m_src,
  input  logic        m_ready,
  output logic        drop_pulse,
  output logic        drop_src,
  output logic        busy
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic        owner, owner_nxt;
  logic [7:0]  hi, hi_nxt;
  logic [7:0]  timer, timer_nxt;
  logic        rr, rr_nxt;
  logic        m_valid_nxt;
  logic [15:0] m_data_nxt;
  logic        m_src_nxt;
  logic        drop_pulse_nxt;
  logic        drop_src_nxt;

  logic        grant;
  logic        owner_valid;
  logic [7:0]  owner_data;
  logic        out_free;

  // On a tie the requester that did not finish the last pair wins.
  assign grant       = (s0_valid && s1_valid) ? ~rr : s1_valid;
  assign owner_valid = owner ? s1_valid : s0_valid;
  assign owner_data  = owner ? s1_data : s0_data;
  assign out_free    = ~m_valid | m_ready;
  assign busy        = (state != IDLE) | m_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      hi         <= '0;
      timer      <= '0;
      rr         <= 1'b1;
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_src      <= 1'b0;
      drop_pulse <= 1'b0;
      drop_src   <= 1'b0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      hi         <= hi_nxt;
      timer      <= timer_nxt;
      rr         <= rr_nxt;
      m_valid    <= m_valid_nxt;
      m_data     <= m_data_nxt;
      m_src      <= m_src_nxt;
      drop_pulse <= drop_pulse_nxt;
      drop_src   <= drop_src_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    hi_nxt         = hi;
    timer_nxt      = timer;
    rr_nxt         = rr;
    m_valid_nxt    = m_valid & ~m_ready;
    m_data_nxt     = m_data;
    m_src_nxt      = m_src;
    drop_pulse_nxt = 1'b0;
    drop_src_nxt   = drop_src;
    s0_ready       = 1'b0;
    s1_ready       = 1'b0;

    case (state)
      IDLE: begin
        if (s0_valid || s1_valid) begin
          s0_ready  = ~grant;
          s1_ready  = grant;
          hi_nxt    = grant ? s1_data : s0_data;
          owner_nxt = grant;
          timer_nxt = '0;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        s0_ready = ~owner & out_free;
        s1_ready = owner & out_free;
        if (owner_valid && out_free) begin
          m_data_nxt  = {hi, owner_data};
          m_src_nxt   = owner;
          m_valid_nxt = 1'b1;
          rr_nxt      = owner;
          state_nxt   = IDLE;
        end else if (!owner_valid) begin
          // Only cycles with the owner silent advance the timer; backpressure freezes it.
          if (timer == TIMER_LAST) begin
            drop_pulse_nxt = 1'b1;
            drop_src_nxt   = owner;
            rr_nxt         = owner;
            hi_nxt         = '0;
            state_nxt      = IDLE;
          end else begin
            timer_nxt = timer + 8'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_width_8to16_arb.sv
// Directed self-checking bench for width_8to16_arb (instantiated with TIMEOUT=4).
module tb_width_8to16_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        s0_valid, s1_valid;
  logic [7:0]  s0_data, s1_data;
  logic        s0_ready, s1_ready;
  logic        m_valid;
  logic [15:0] m_data;
  logic        m_src;
  logic        m_ready;
  logic        drop_pulse, drop_src, busy;

  int n_checks = 0;
  int n_errors = 0;

  width_8to16_arb #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .s0_valid(s0_valid), .s0_data(s0_data), .s0_ready(s0_ready),
    .s1_valid(s1_valid), .s1_data(s1_data), .s1_ready(s1_ready),
    .m_valid(m_valid), .m_data(m_data), .m_src(m_src), .m_ready(m_ready),
    .drop_pulse(drop_pulse), .drop_src(drop_src), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    s0_valid = 1'b0; s1_valid = 1'b0; s0_data = '0; s1_data = '0; m_ready = 1'b1;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  logic [7:0]  b0 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0]  b1 [4] = '{8'h55, 8'h66, 8'h77, 8'h88};
  logic [15:0] exp_w [4] = '{16'h1122, 16'h5566, 16'h3344, 16'h7788};
  logic        exp_s [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int i0, i1, nw, both_hs;
    logic hs0, hs1;

    // Reset state
    do_reset();
    check("rst_m_valid", 16'(m_valid), 16'd0);
    check("rst_m_data", m_data, 16'h0000);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_ready", {14'd0, s1_ready, s0_ready}, 16'd0);
    check("rst_drop", 16'(drop_pulse), 16'd0);

    // Single source
    s0_valid = 1'b1; s0_data = 8'hA5;
    #1;
    check("single_r0_first", 16'(s0_ready), 16'd1);
    check("single_r1_first", 16'(s1_ready), 16'd0);
    tick();
    s0_data = 8'h3C;
    #1;
    check("single_r0_second", 16'(s0_ready), 16'd1);
    check("single_r1_second", 16'(s1_ready), 16'd0);
    tick();
    s0_valid = 1'b0;
    check("single_valid", 16'(m_valid), 16'd1);
    check("single_data", m_data, 16'hA53C);
    check("single_src", 16'(m_src), 16'd0);
    tick();
    check("single_valid_clear", 16'(m_valid), 16'd0);

    // Timeout: rr now points at s0, so s1 wins the tie
    s0_valid = 1'b1; s0_data = 8'h42;
    s1_valid = 1'b1; s1_data = 8'h9A;
    #1;
    check("to_grant_s1", {14'd0, s1_ready, s0_ready}, 16'b10);
    tick();
    s1_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("to_no_drop_yet", 16'(drop_pulse), 16'd0);
      check("to_s0_blocked", 16'(s0_ready), 16'd0);
    end
    tick();
    check("to_drop_pulse", 16'(drop_pulse), 16'd1);
    check("to_drop_src", 16'(drop_src), 16'd1);
    check("to_m_valid", 16'(m_valid), 16'd0);
    check("to_s0_granted", 16'(s0_ready), 16'd1);
    tick();
    check("to_drop_one_cycle", 16'(drop_pulse), 16'd0);
    s0_data = 8'h43;
    tick();
    s0_valid = 1'b0;
    check("to_next_word", m_data, 16'h4243);
    check("to_next_src", 16'(m_src), 16'd0);
    tick();

    // Owner byte arrives in the timeout cycle
    s0_valid = 1'b1; s0_data = 8'h55;
    s1_valid = 1'b1; s1_data = 8'h9A;
    #1;
    check("late_grant_s1", 16'(s1_ready), 16'd1);
    tick();
    s1_valid = 1'b0;
    tick(); tick(); tick();
    s1_valid = 1'b1; s1_data = 8'hBC;
    #1;
    check("late_s1_ready", 16'(s1_ready), 16'd1);
    tick();
    s0_valid = 1'b0; s1_valid = 1'b0;
    check("late_no_drop", 16'(drop_pulse), 16'd0);
    check("late_word", m_data, 16'h9ABC);
    check("late_src", 16'(m_src), 16'd1);
    check("late_valid", 16'(m_valid), 16'd1);
    tick();

    // Backpressure
    m_ready = 1'b0;
    s0_valid = 1'b1; s0_data = 8'h12;
    tick();
    s0_data = 8'h34;
    tick();
    check("bp_pending", m_data, 16'h1234);
    s0_data = 8'hBE;
    #1;
    check("bp_first_accepted", 16'(s0_ready), 16'd1);
    tick();
    s0_data = 8'hEF;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("bp_blocked", 16'(s0_ready), 16'd0);
      check("bp_no_drop", 16'(drop_pulse), 16'd0);
      tick();
    end
    check("bp_hold_data", m_data, 16'h1234);
    check("bp_hold_valid", 16'(m_valid), 16'd1);
    m_ready = 1'b1;
    #1;
    check("bp_release_ready", 16'(s0_ready), 16'd1);
    check("bp_drain_word", m_data, 16'h1234);
    tick();
    s0_valid = 1'b0;
    check("bp_no_bubble", 16'(m_valid), 16'd1);
    check("bp_next_word", m_data, 16'hBEEF);
    tick();
    check("bp_drained", 16'(m_valid), 16'd0);

    // Contention and fairness from a fresh reset (s0 has first priority)
    do_reset();
    i0 = 0; i1 = 0; nw = 0; both_hs = 0;
    for (int cyc = 0; cyc < 24 && nw < 4; cyc++) begin
      s0_valid = (i0 < 4); s0_data = b0[i0 & 3];
      s1_valid = (i1 < 4); s1_data = b1[i1 & 3];
      #1;
      hs0 = s0_valid && s0_ready;
      hs1 = s1_valid && s1_ready;
      if (hs0 && hs1) both_hs++;
      if (m_valid) begin
        check("cont_word", m_data, exp_w[nw]);
        check("cont_src", 16'(m_src), 16'(exp_s[nw]));
        nw++;
      end
      tick();
      if (hs0) i0++;
      if (hs1) i1++;
    end
    check("cont_word_count", 16'(nw), 16'd4);
    check("cont_no_dual_accept", 16'(both_hs), 16'd0);
    s0_valid = 1'b0; s1_valid = 1'b0;
    tick();

    // Reset mid-operation: word pending and a pair half received
    m_ready = 1'b0;
    s0_valid = 1'b1; s0_data = 8'h01;
    tick();
    s0_data = 8'h02;
    tick();
    s0_data = 8'h03;
    tick();
    s0_valid = 1'b0;
    check("mid_busy", 16'(busy), 16'd1);
    check("mid_valid", 16'(m_valid), 16'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 16'(m_valid), 16'd0);
    check("mid_rst_data", m_data, 16'h0000);
    check("mid_rst_busy", 16'(busy), 16'd0);
    check("mid_rst_drop", 16'(drop_pulse), 16'd0);
    tick(); tick();
    rst = 1'b0;
    m_ready = 1'b1;
    tick();
    check("post_rst_drop", 16'(drop_pulse), 16'd0);
    s0_valid = 1'b1; s0_data = 8'h77;
    s1_valid = 1'b1; s1_data = 8'h88;
    #1;
    check("post_rst_tie", {14'd0, s1_ready, s0_ready}, 16'b01);
    tick();
    s0_valid = 1'b0; s1_valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
